// File: rtl/stopwatch_watch_ctrl.sv
// Stopwatch/watch control unit: turns debounced button pulses into stopwatch run/clear,
// display-mode select and watch time-set controls. Optional edit timeout: EDIT_TIMEOUT_EN.
module stopwatch_watch_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_btn_run_stop,
   input  logic       i_btn_clear,
   input  logic       i_btn_mode,
   output logic       o_run,
   output logic       o_clear,
   output logic       o_mode,
   output logic       o_edit,
   output logic [1:0] o_sel,
   output logic       o_inc
);

   typedef enum logic [1:0] {SW_STOP, SW_RUN, SW_CLEAR} sw_state_t;
   typedef enum logic {VIEW, EDIT} w_state_t;

   sw_state_t  sw_state_q, sw_state_d;
   w_state_t   w_state_q, w_state_d;
   logic       mode_q, mode_d;
   logic [1:0] sel_q, sel_d;
   logic       inc_q, inc_d;

   logic mode_p, run_stop_p, clear_p;
   logic timeout;

   // A mode pulse masks run_stop and clear; run_stop masks clear.
   always_comb begin
      mode_p     = i_btn_mode;
      run_stop_p = i_btn_run_stop & ~i_btn_mode;
      clear_p    = i_btn_clear & ~i_btn_mode & ~i_btn_run_stop;
   end

`ifdef EDIT_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign timeout = (cnt_q == CNT_LAST);

   // Counts idle cycles in EDIT; held at zero everywhere else so entry starts fresh.
   always_comb begin
      cnt_d = '0;
      if (w_state_q == EDIT && !run_stop_p && !clear_p && !timeout) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   // No inactivity timer in this build; the parameter only keeps the port list uniform.
   assign timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

   always_comb begin
      sw_state_d = sw_state_q;
      w_state_d  = w_state_q;
      mode_d     = mode_q;
      sel_d      = sel_q;
      inc_d      = 1'b0;

      if (mode_p && w_state_q != EDIT) begin
         mode_d = ~mode_q;
      end

      case (sw_state_q)
         SW_STOP: begin
            if (!mode_q) begin
               if (run_stop_p) begin
                  sw_state_d = SW_RUN;
               end else if (clear_p) begin
                  sw_state_d = SW_CLEAR;
               end
            end
         end
         SW_RUN: begin
            if (!mode_q && run_stop_p) begin
               sw_state_d = SW_STOP;
            end
         end
         default: sw_state_d = SW_STOP;
      endcase

      // EDIT is only reachable with mode set, and mode cannot change while editing.
      case (w_state_q)
         VIEW: begin
            if (mode_q && run_stop_p) begin
               w_state_d = EDIT;
               sel_d     = 2'd0;
            end
         end
         default: begin
            if (run_stop_p) begin
               if (sel_q == 2'd2) begin
                  w_state_d = VIEW;
                  sel_d     = 2'd0;
               end else begin
                  sel_d = sel_q + 2'd1;
               end
            end else if (clear_p) begin
               inc_d = 1'b1;
            end else if (timeout) begin
               w_state_d = VIEW;
               sel_d     = 2'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_state_q <= SW_STOP;
         w_state_q  <= VIEW;
         mode_q     <= 1'b0;
         sel_q      <= 2'd0;
         inc_q      <= 1'b0;
      end else begin
         sw_state_q <= sw_state_d;
         w_state_q  <= w_state_d;
         mode_q     <= mode_d;
         sel_q      <= sel_d;
         inc_q      <= inc_d;
      end
   end

   assign o_run   = (sw_state_q == SW_RUN);
   assign o_clear = (sw_state_q == SW_CLEAR);
   assign o_mode  = mode_q;
   assign o_edit  = (w_state_q == EDIT);
   assign o_sel   = sel_q;
   assign o_inc   = inc_q;

endmodule

// File: tb/tb_stopwatch_watch_ctrl.sv
// Scoreboard bench for stopwatch_watch_ctrl: directed plan plus randomized pulses,
// checked against a behavioural model of the button rules.
module tb_stopwatch_watch_ctrl;

   localparam int T = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       i_btn_run_stop = 1'b0;
   logic       i_btn_clear = 1'b0;
   logic       i_btn_mode = 1'b0;
   logic       o_run, o_clear, o_mode, o_edit, o_inc;
   logic [1:0] o_sel;

   stopwatch_watch_ctrl #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset),
      .i_btn_run_stop(i_btn_run_stop), .i_btn_clear(i_btn_clear), .i_btn_mode(i_btn_mode),
      .o_run(o_run), .o_clear(o_clear), .o_mode(o_mode), .o_edit(o_edit),
      .o_sel(o_sel), .o_inc(o_inc)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [6:0] exp_q[$];
   bit driver_done = 0;

   // Behavioural model state
   bit m_run, m_clear, m_mode, m_edit, m_inc;
   int m_sel, m_cnt;

   function automatic logic [6:0] dut_vec();
      return {o_run, o_clear, o_mode, o_edit, o_sel, o_inc};
   endfunction

   function automatic logic [6:0] model_vec();
      logic [1:0] s;
      s = 2'(m_sel);
      return {m_run, m_clear, m_mode, m_edit, s, m_inc};
   endfunction

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got {run,clr,mode,edit,sel,inc}=%b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_clear = 0; m_mode = 0; m_edit = 0; m_inc = 0; m_sel = 0; m_cnt = 0;
   endtask

   task automatic model_step(input bit rs, input bit cl, input bit md);
      bit acc_rs, acc_cl, was_clear, was_edit;
      acc_rs = rs && !md;
      acc_cl = cl && !md && !rs;
      was_clear = m_clear;
      was_edit = m_edit;
      m_clear = 0;
      m_inc = 0;
      if (md && !was_edit) m_mode = !m_mode;
      else if (!md && !m_mode && !was_clear) begin
         if (acc_rs) m_run = !m_run;
         else if (acc_cl && !m_run) m_clear = 1;
      end else if (!md && m_mode) begin
         if (!was_edit && acc_rs) begin
            m_edit = 1; m_sel = 0; m_cnt = 0;
         end else if (was_edit && acc_rs) begin
            m_cnt = 0;
            if (m_sel == 2) begin m_edit = 0; m_sel = 0; end
            else m_sel = m_sel + 1;
         end else if (was_edit && acc_cl) begin
            m_cnt = 0; m_inc = 1;
         end
      end
`ifdef EDIT_TIMEOUT_EN
      if (was_edit && !acc_rs && !acc_cl) begin
         if (m_cnt == T - 1) begin m_edit = 0; m_sel = 0; m_cnt = 0; end
         else m_cnt = m_cnt + 1;
      end
`endif
   endtask

   task automatic step(input bit rs, input bit cl, input bit md);
      @(negedge clk);
      // A mode pulse in edit is ignored; keep it alone so the cycle's meaning is unambiguous.
      if (m_edit && md) begin rs = 0; cl = 0; end
      reset = 1'b1;
      i_btn_run_stop = rs; i_btn_clear = cl; i_btn_mode = md;
      model_step(rs, cl, md);
      exp_q.push_back(model_vec());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0);
   endtask

   task automatic hold_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset = 1'b0;
         i_btn_run_stop = 0; i_btn_clear = 0; i_btn_mode = 0;
         model_reset();
         exp_q.push_back(model_vec());
      end
   endtask

   // Drops reset mid-cycle and checks the outputs clear before any clock edge.
   task automatic async_reset();
      @(negedge clk);
      i_btn_run_stop = 0; i_btn_clear = 0; i_btn_mode = 0;
      #2 reset = 1'b0;
      #1 check("async_reset", dut_vec(), 7'b0);
      model_reset();
      exp_q.push_back(model_vec());
   endtask

   // Monitor: every clock the DUT presents a new registered output word.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) check("outputs", dut_vec(), exp_q.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t got no completion expected completion", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      hold_reset(3);
      // Stopwatch run/stop and clear behaviour
      step(1, 0, 0); idle(10); step(1, 0, 0);
      step(0, 1, 0); idle(1); step(0, 1, 0); step(0, 1, 0);
      step(1, 0, 0); step(0, 1, 0); idle(2); step(1, 0, 0);
      // Running stopwatch survives a switch to watch edit
      step(1, 0, 0); step(0, 0, 1); step(1, 0, 0); step(0, 0, 1);
      step(0, 1, 0); step(0, 1, 0); step(0, 1, 0); step(1, 0, 0);
      step(0, 1, 0); step(1, 0, 0); step(1, 0, 0); idle(2);
      // Back to stopwatch, stop it, then mode+clear together
      step(0, 0, 1); step(1, 0, 0); step(0, 1, 1); idle(2);
      // Reset in the middle of an o_inc pulse
      step(1, 0, 0); step(0, 1, 0); async_reset(); idle(1);
      // Edit inactivity: full idle run, then a clear near expiry
      step(0, 0, 1); step(1, 0, 0); idle(T + 3);
      step(1, 0, 0); idle(T - 2); step(0, 1, 0); idle(T - 1); idle(3);
      step(1, 1, 1); step(1, 1, 0); step(0, 1, 1);
      // Randomized phases with varying pulse density
      for (int ph = 0; ph < 40; ph++) begin
         int d;
         d = $urandom_range(2, 40);
         for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 299) == 0) async_reset();
            else step($urandom_range(0, d - 1) == 0, $urandom_range(0, d - 1) == 0,
                      $urandom_range(0, 2 * d - 1) == 0);
         end
      end
      driver_done = 1;
      repeat (3) @(posedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
